// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
// Writeback stage that drives the single write port of the register file.
// It merges load returns and ALU results into one write per cycle. Load
// returns always win the port. An ALU result that loses arbitration, or
// that arrives while older ALU results are still queued, waits in a small
// in-order FIFO. Decode can read the FIFO's destinations on pending_mask.
//
// Ports:
//   clk, reset    rising-edge clock; asynchronous active-high reset
//   alu_valid/alu_ready/alu_sel/alu_data
//                 ALU result channel (ready/valid). alu_ready depends on
//                 the FIFO count only.
//   ld_valid/ld_sel/ld_data
//                 load return channel. It has no backpressure and is
//                 always accepted.
//   wr_en/wr_sel/wr_data
//                 registered register-file write port. wr_sel and wr_data
//                 hold their values while wr_en=0.
//   pending_mask  one bit per register; set while any buffered entry
//                 targets that register
//   fifo_count    number of buffered ALU results
module reg_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [SEL_W-1:0]         alu_sel,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_valid,
  input  logic [SEL_W-1:0]         ld_sel,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     wr_en,
  output logic [SEL_W-1:0]         wr_sel,
  output logic [DATA_W-1:0]        wr_data,
  output logic [(2**SEL_W)-1:0]    pending_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [SEL_W-1:0]  mem_sel  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;

  logic fifo_empty;
  logic alu_xfer;
  logic pop;
  logic bypass;
  logic push;

  assign fifo_empty = (fifo_count == '0);
  assign alu_ready  = (fifo_count != CW'(DEPTH));
  assign alu_xfer   = alu_valid & alu_ready;

  // A load takes the port first. Next comes the FIFO head. The ALU result
  // goes straight through only when nothing older is waiting.
  assign pop    = ~ld_valid & ~fifo_empty;
  assign bypass = ~ld_valid & fifo_empty & alu_xfer;
  assign push   = alu_xfer & ~bypass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_sel     <= '0;
      wr_data    <= '0;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fifo_count <= '0;
    end else begin
      if (ld_valid) begin
        wr_en   <= 1'b1;
        wr_sel  <= ld_sel;
        wr_data <= ld_data;
      end else if (pop) begin
        wr_en   <= 1'b1;
        wr_sel  <= mem_sel[head_ptr];
        wr_data <= mem_data[head_ptr];
      end else if (bypass) begin
        wr_en   <= 1'b1;
        wr_sel  <= alu_sel;
        wr_data <= alu_data;
      end else begin
        wr_en   <= 1'b0;
      end

      if (pop)  head_ptr <= head_ptr + PW'(1);
      if (push) tail_ptr <= tail_ptr + PW'(1);

      // A push cannot happen while the FIFO is full because alu_ready is
      // low then, so the count never goes past DEPTH.
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The storage needs no reset. Entries outside the head..count window are
  // never read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sel[tail_ptr]  <= alu_sel;
      mem_data[tail_ptr] <= alu_data;
    end
  end

  // Only the occupied window starting at the head is counted. An entry
  // popped at an edge has already left that window when it appears on wr_*.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (CW'(i) < fifo_count) pending_mask[mem_sel[idx]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alu_valid = 1'b0;
  logic       alu_ready;
  logic [1:0] alu_sel = '0;
  logic [7:0] alu_data = '0;
  logic       ld_valid = 1'b0;
  logic [1:0] ld_sel = '0;
  logic [7:0] ld_data = '0;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic [3:0] pending_mask;
  logic [1:0] fifo_count;

  reg_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(8), .SEL_W(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_sel(alu_sel), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_data(ld_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {sel,data} holding the waiting ALU results,
  // the expected write port, and the expected register file contents.
  logic [9:0] q[$];
  logic       exp_en;
  logic [1:0] exp_sel;
  logic [7:0] exp_data;
  logic [7:0] exp_reg [4];
  logic [7:0] dut_reg [4];

  always @(posedge clk) if (wr_en === 1'b1) dut_reg[wr_sel] <= wr_data;

  function automatic logic [3:0] mdl_mask();
    logic [3:0] m = '0;
    foreach (q[i]) m[q[i][9:8]] = 1'b1;
    return m;
  endfunction

  task automatic mdl_reset();
    q.delete();
    exp_en = 1'b0; exp_sel = '0; exp_data = '0;
  endtask

  // Applies one cycle of stimulus, advances the model, and returns at
  // posedge+1. xfer reports whether the ALU result was accepted.
  task automatic cycle(input logic lv, input logic [1:0] ls, input logic [7:0] ld,
                       input logic av, input logic [1:0] as_, input logic [7:0] ad,
                       output logic xfer);
    logic x, wrote_alu;
    logic [9:0] e;
    ld_valid = lv; ld_sel = ls; ld_data = ld;
    alu_valid = av; alu_sel = as_; alu_data = ad;
    x = av && (q.size() != DEPTH);
    wrote_alu = 1'b0;
    if (lv) begin
      exp_en = 1'b1; exp_sel = ls; exp_data = ld;
    end else if (q.size() != 0) begin
      e = q.pop_front();
      exp_en = 1'b1; exp_sel = e[9:8]; exp_data = e[7:0];
    end else if (x) begin
      exp_en = 1'b1; exp_sel = as_; exp_data = ad; wrote_alu = 1'b1;
    end else begin
      exp_en = 1'b0;
    end
    if (x && !wrote_alu) q.push_back({as_, ad});
    if (exp_en) exp_reg[exp_sel] = exp_data;
    @(posedge clk); #1;
    xfer = x;
  endtask

  task automatic idle();
    logic x;
    cycle(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, x);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b want 0", wr_en); end
    checks++; if (wr_sel !== 2'd0) begin errors++; $display("FAIL reset_wr_sel got %0d want 0", wr_sel); end
    checks++; if (wr_data !== 8'd0) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    checks++; if (pending_mask !== 4'd0) begin errors++; $display("FAIL reset_mask got %b want 0000", pending_mask); end
    @(negedge clk) reset = 1'b0;
    mdl_reset();
    @(posedge clk); #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", alu_ready); end
  endtask

  task automatic test_bypass();
    logic x;
    cycle(1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 8'h5A, x);
    checks++; if (wr_en !== 1'b1 || wr_sel !== 2'd2 || wr_data !== 8'h5A)
      begin errors++; $display("FAIL bypass_write got en=%0b sel=%0d data=%h want 1/2/5a", wr_en, wr_sel, wr_data); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL bypass_count got %0d want 0", fifo_count); end
    idle();
    checks++; if (wr_en !== 1'b0 || wr_sel !== 2'd2 || wr_data !== 8'h5A)
      begin errors++; $display("FAIL bypass_hold got en=%0b sel=%0d data=%h want 0/2/5a", wr_en, wr_sel, wr_data); end
  endtask

  task automatic test_collision();
    logic x;
    cycle(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, x);
    checks++; if (wr_en !== 1'b1 || wr_sel !== 2'd1 || wr_data !== 8'h11)
      begin errors++; $display("FAIL coll_ld got en=%0b sel=%0d data=%h want 1/1/11", wr_en, wr_sel, wr_data); end
    checks++; if (fifo_count !== 2'd1 || pending_mask !== 4'b1000)
      begin errors++; $display("FAIL coll_buf got count=%0d mask=%b want 1/1000", fifo_count, pending_mask); end
    idle();
    checks++; if (wr_en !== 1'b1 || wr_sel !== 2'd3 || wr_data !== 8'h33)
      begin errors++; $display("FAIL coll_alu got en=%0b sel=%0d data=%h want 1/3/33", wr_en, wr_sel, wr_data); end
    checks++; if (fifo_count !== 2'd0 || pending_mask !== 4'b0000)
      begin errors++; $display("FAIL coll_drain got count=%0d mask=%b want 0/0000", fifo_count, pending_mask); end
  endtask

  task automatic test_fill_backpressure();
    logic [1:0] isel [3];
    logic [7:0] idat [3];
    logic       ready_pre [4];
    int p;
    logic x;
    isel[0] = 2'd0; idat[0] = 8'hA0;
    isel[1] = 2'd1; idat[1] = 8'hB1;
    isel[2] = 2'd2; idat[2] = 8'hC2;
    ready_pre[0] = 1'b1; ready_pre[1] = 1'b1; ready_pre[2] = 1'b0; ready_pre[3] = 1'b0;
    p = 0;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_sel = isel[p]; alu_data = idat[p]; #1;
      checks++; if (alu_ready !== ready_pre[k])
        begin errors++; $display("FAIL fill_ready%0d got %0b want %0b", k, alu_ready, ready_pre[k]); end
      cycle(1'b1, 2'd3, 8'h40 + 8'(k), 1'b1, isel[p], idat[p], x);
      if (x) p++;
    end
    checks++; if (fifo_count !== 2'd2 || pending_mask !== 4'b0011)
      begin errors++; $display("FAIL fill_full got count=%0d mask=%b want 2/0011", fifo_count, pending_mask); end
    cycle(1'b0, 2'd0, 8'd0, 1'b1, isel[2], idat[2], x);
    checks++; if (wr_sel !== 2'd0 || wr_data !== 8'hA0 || x !== 1'b0)
      begin errors++; $display("FAIL fill_popA got sel=%0d data=%h xfer=%0b want 0/a0/0", wr_sel, wr_data, x); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop got %0b want 1", alu_ready); end
    cycle(1'b0, 2'd0, 8'd0, 1'b1, isel[2], idat[2], x);
    checks++; if (wr_sel !== 2'd1 || wr_data !== 8'hB1 || fifo_count !== 2'd1 || pending_mask !== 4'b0100)
      begin errors++; $display("FAIL fill_popB got sel=%0d data=%h count=%0d mask=%b want 1/b1/1/0100", wr_sel, wr_data, fifo_count, pending_mask); end
    idle();
    checks++; if (wr_en !== 1'b1 || wr_sel !== 2'd2 || wr_data !== 8'hC2 || fifo_count !== 2'd0)
      begin errors++; $display("FAIL fill_popC got en=%0b sel=%0d data=%h count=%0d want 1/2/c2/0", wr_en, wr_sel, wr_data, fifo_count); end
  endtask

  task automatic test_waw();
    logic x;
    cycle(1'b1, 2'd0, 8'hAA, 1'b1, 2'd0, 8'hBB, x);
    checks++; if (wr_sel !== 2'd0 || wr_data !== 8'hAA || pending_mask !== 4'b0001)
      begin errors++; $display("FAIL waw_first got sel=%0d data=%h mask=%b want 0/aa/0001", wr_sel, wr_data, pending_mask); end
    idle();
    checks++; if (wr_sel !== 2'd0 || wr_data !== 8'hBB)
      begin errors++; $display("FAIL waw_second got sel=%0d data=%h want 0/bb", wr_sel, wr_data); end
    idle();
    checks++; if (dut_reg[0] !== 8'hBB) begin errors++; $display("FAIL waw_final got %h want bb", dut_reg[0]); end
  endtask

  task automatic test_push_pop();
    logic x;
    logic [7:0] want;
    cycle(1'b1, 2'd2, 8'h77, 1'b1, 2'd1, 8'h01, x);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 2'd0, 8'd0, 1'b1, 2'(i), 8'h10 + 8'(i), x);
      want = (i == 0) ? 8'h01 : 8'h10 + 8'(i - 1);
      checks++; if (wr_en !== 1'b1 || wr_data !== want || fifo_count !== 2'd1)
        begin errors++; $display("FAIL pushpop%0d got en=%0b data=%h count=%0d want 1/%h/1", i, wr_en, wr_data, fifo_count, want); end
    end
    idle();
    checks++; if (wr_data !== 8'h17 || fifo_count !== 2'd0)
      begin errors++; $display("FAIL pushpop_drain got data=%h count=%0d want 17/0", wr_data, fifo_count); end
  endtask

  task automatic test_random();
    logic pv, lv, x;
    logic [1:0] ps, ls;
    logic [7:0] pd, ld;
    int n;
    pv = 1'b0; ps = '0; pd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 9) < 7);
        ps = 2'($urandom_range(0, 3));
        pd = 8'($urandom_range(0, 255));
      end
      lv = ($urandom_range(0, 9) < 4);
      ls = 2'($urandom_range(0, 3));
      ld = 8'($urandom_range(0, 255));
      alu_valid = pv; #1;
      checks++; if (alu_ready !== (q.size() != DEPTH))
        begin errors++; $display("FAIL rnd_ready c=%0d got %0b want %0b", c, alu_ready, q.size() != DEPTH); end
      cycle(lv, ls, ld, pv, ps, pd, x);
      if (x) pv = 1'b0;
      checks++; if (wr_en !== exp_en || wr_sel !== exp_sel || wr_data !== exp_data)
        begin errors++; $display("FAIL rnd_write c=%0d got %0b/%0d/%h want %0b/%0d/%h", c, wr_en, wr_sel, wr_data, exp_en, exp_sel, exp_data); end
      checks++; if (fifo_count !== 2'(q.size()) || pending_mask !== mdl_mask())
        begin errors++; $display("FAIL rnd_fifo c=%0d got count=%0d mask=%b want %0d/%b", c, fifo_count, pending_mask, q.size(), mdl_mask()); end
    end
    n = 0;
    while (q.size() != 0 && n < 10) begin idle(); n++; end
    idle(); idle();
    for (int r = 0; r < 4; r++) begin
      checks++; if (dut_reg[r] !== exp_reg[r])
        begin errors++; $display("FAIL rnd_regfile r%0d got %h want %h", r, dut_reg[r], exp_reg[r]); end
    end
  endtask

  task automatic test_async_reset();
    logic x;
    cycle(1'b1, 2'd0, 8'hC1, 1'b1, 2'd1, 8'hD1, x);
    cycle(1'b1, 2'd1, 8'hC2, 1'b1, 2'd2, 8'hD2, x);
    checks++; if (fifo_count !== 2'd2 || wr_en !== 1'b1)
      begin errors++; $display("FAIL arst_pre got count=%0d en=%0b want 2/1", fifo_count, wr_en); end
    ld_valid = 1'b0; alu_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0 || wr_sel !== 2'd0 || wr_data !== 8'd0)
      begin errors++; $display("FAIL arst_wr got en=%0b sel=%0d data=%h want 0/0/00", wr_en, wr_sel, wr_data); end
    checks++; if (fifo_count !== 2'd0 || pending_mask !== 4'd0)
      begin errors++; $display("FAIL arst_fifo got count=%0d mask=%b want 0/0000", fifo_count, pending_mask); end
    @(negedge clk) reset = 1'b0;
    mdl_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++; if (wr_en !== 1'b0 || fifo_count !== 2'd0)
        begin errors++; $display("FAIL arst_post%0d got en=%0b count=%0d want 0/0", i, wr_en, fifo_count); end
    end
  endtask

  initial begin
    for (int r = 0; r < 4; r++) begin exp_reg[r] = 8'd0; dut_reg[r] = 8'd0; end
    mdl_reset();
    test_reset();
    test_bypass();
    test_collision();
    test_fill_backpressure();
    test_waw();
    test_push_pop();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Writeback stage directly upstream of the 4x8-bit register file; sole driver of its write port (wr_en/wr_sel/wr_data).
- Merges two result sources: ALU results (execute stage, ready/valid handshake) and memory load returns (no backpressure, always accepted).
- Load returns have priority; colliding ALU results are held in a small in-order FIFO.
- Exports a pending-write mask so decode can stall on RAW against buffered results.

Parameters:
- DEPTH, 2, ALU result FIFO entries (power of 2, 2..4).
- DATA_W, 8, result data width.
- SEL_W, 2, register select width (2^SEL_W registers).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  stage can accept an ALU result this cycle.
- alu_sel  in  SEL_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- ld_valid  in  1  load return present; must be accepted this cycle.
- ld_sel  in  SEL_W  load destination register.
- ld_data  in  DATA_W  load data.
- wr_en  out  1  register-file write enable (registered).
- wr_sel  out  SEL_W  register-file write select (registered).
- wr_data  out  DATA_W  register-file write data (registered).
- pending_mask  out  2^SEL_W  one-hot OR of destinations of all FIFO entries.
- fifo_count  out  $clog2(DEPTH)+1  number of buffered ALU results.

Behaviour:
- Reset (async, immediate): wr_en=0, wr_sel=0, wr_data=0, FIFO emptied (count=0, pointers=0), pending_mask=0. alu_ready=1 one cycle after reset deasserts.
- ALU transfer occurs on alu_valid & alu_ready at a rising edge. alu_ready = (fifo_count != DEPTH), combinational from count only, with no dependence on alu_valid or ld_valid.
- Per-cycle write source selection, evaluated combinationally and registered onto wr_* at the edge (1-cycle latency):
  - 1: ld_valid, write the load.
  - 2: else FIFO non-empty, write the FIFO head and pop it.
  - 3: else ALU transfer, write the ALU result directly (bypass; it does not enter the FIFO).
  - 4: else wr_en=0; wr_sel/wr_data hold their previous values.
- An ALU transfer not written this cycle is pushed to the FIFO tail. Cases:
  - ld_valid=1: ALU result is pushed.
  - FIFO non-empty: ALU result is pushed; order is preserved behind the head.
- Push and pop in the same cycle: count unchanged, pointers both advance modulo DEPTH.
- Full FIFO: alu_ready=0; the ALU source holds its data. A pop while full frees a slot, but alu_ready rises only on the next cycle.
- Ordering contract: a load return is always older than any ALU result buffered or arriving in the same cycle.
  - Same-register collision: the load writes first, the ALU value is written later and is the final register content (correct WAW order).
  - The block performs no sel comparison.
- pending_mask: bit r is 1 iff any valid FIFO entry has sel=r. It is updated from registered FIFO state and excludes the entry being written this cycle on wr_*.
- Starvation: continuous ld_valid stalls FIFO drain indefinitely; this is the required behaviour, bounded by the memory unit.
- Reset mid-operation: buffered ALU results are discarded; wr_en drops immediately (async).
- Widths: no arithmetic on data; pointers wrap modulo DEPTH; count saturates only at DEPTH.

Test Plan:
- Bypass: FIFO empty, alu_valid=1, sel=2, data=0x5A, ld_valid=0 -> next cycle wr_en=1, wr_sel=2, wr_data=0x5A; fifo_count=0.
- Collision: ld_valid=1 (sel=1, 0x11) and alu_valid=1 (sel=3, 0x33) in the same cycle -> cycle+1 writes r1=0x11, fifo_count=1, pending_mask=4'b1000; cycle+2 writes r3=0x33, count=0, mask=0.
- Fill/backpressure: DEPTH=2, ld_valid held 1 for 4 cycles with ALU results A(sel0), B(sel1), C(sel2) offered -> A and B accepted, alu_ready=0 while count=2, C held. After ld_valid drops: writes A, B, C in order; alu_ready returns 1 the cycle after the first pop.
- WAW same register: ld (sel=0, 0xAA) and ALU (sel=0, 0xBB) in the same cycle -> writes 0xAA then 0xBB; reg0 ends 0xBB.
- Simultaneous push/pop: count=1, ld_valid=0, ALU transfer -> head written, new entry pushed, count stays 1, order preserved over 8 back-to-back results.
- Async reset: assert reset mid-cycle with count=2, wr_en=1 -> wr_en, wr_sel, wr_data, fifo_count, pending_mask all 0 without waiting for a clock edge; no buffered entry is written after release.
